iterative_restoring_divider_64_32: RTL

- Iterative unsigned restoring divider; the inverse of the iterative Karatsuba multiplier path.
- Divides a 2N-bit dividend (e.g. a 64-bit product) by an N-bit divisor, producing an N-bit quotient and an N-bit remainder.
- Uses one shared (N+1)-bit subtractor, one quotient bit per cycle, sequenced by a small control FSM.
- Sits beside the multiplier in the arithmetic unit; also serves as a round-trip checker for multiplier results.

---
 rtl/iterative_restoring_divider_64_32_pkg.sv | 15 +
 rtl/iterative_restoring_divider_64_32_step.sv | 37 +++
 rtl/iterative_restoring_divider_64_32.sv | 123 ++++++++++++
 3 files changed

// File: rtl/iterative_restoring_divider_64_32_pkg.sv
// Shared definitions for the iterative restoring divider: one-hot control
// states and the default operand width.
package iterative_restoring_divider_64_32_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_CHECK = 4'b0010,
        S_ITER  = 4'b0100,
        S_DONE  = 4'b1000
    } div_state_t;

    localparam int DIV_N = 32;
    localparam int CNT_W = $clog2(DIV_N);

endpackage

// File: rtl/iterative_restoring_divider_64_32_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not borrow.
module div_restore_step #(
    parameter int N = 32
) (
    input  logic [N:0]   i_r,
    input  logic         i_q_msb,
    input  logic [N-1:0] i_d,
    output logic [N:0]   o_r_next,
    output logic         o_q_bit
);

    logic [N:0]   w_s;
    logic [N:0]   w_b;
    logic [N:0]   w_t;
    logic [N+1:0] w_c;
    logic         w_unused_r_msb;

    // R < D holds between steps, so R's top bit is always 0 and S still fits.
    assign w_unused_r_msb = i_r[N];
    assign w_s            = {i_r[N-1:0], i_q_msb};
    assign w_b            = ~{1'b0, i_d};
    assign w_c[0]         = 1'b1;

    // Two's-complement subtract on a ripple full-adder chain: S + ~D + 1.
    generate
        for (genvar gi = 0; gi <= N; gi++) begin : g_fa
            assign w_t[gi]   = w_s[gi] ^ w_b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (w_s[gi] & w_b[gi]) | (w_c[gi] & (w_s[gi] ^ w_b[gi]));
        end
    endgenerate

    // Carry out of the chain means no borrow: S >= D.
    assign o_q_bit  = w_c[N+1];
    assign o_r_next = w_c[N+1] ? w_t : w_s;

endmodule

// File: rtl/iterative_restoring_divider_64_32.sv
// Iterative unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per cycle through a shared (N+1)-bit subtractor.
module iterative_restoring_divider_64_32
    import iterative_restoring_divider_64_32_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N);

    div_state_t    r_state;
    div_state_t    w_state_next;
    logic [N-1:0]  r_d;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_q;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_dbz;
    logic          r_ovf;
    logic [N:0]    w_r_next;
    logic          w_q_bit;
    logic [N-1:0]  w_q_next;

    div_restore_step #(.N(N)) u_step (
        .i_r      (r_rem),
        .i_q_msb  (r_q[N-1]),
        .i_d      (r_d),
        .o_r_next (w_r_next),
        .o_q_bit  (w_q_bit)
    );

    assign w_q_next = {r_q[N-2:0], w_q_bit};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CHECK;
            S_CHECK: begin
                if (r_d == '0 || r_rem[N-1:0] >= r_d) w_state_next = S_DONE;
                else                                  w_state_next = S_ITER;
            end
            S_ITER:  if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_d   <= divisor;
                        r_rem <= {1'b0, dividend[2*N-1:N]};
                        r_q   <= dividend[N-1:0];
                        r_dbz <= 1'b0;
                        r_ovf <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (r_d == '0) begin
                        r_dbz       <= 1'b1;
                        r_quotient  <= '1;
                        r_remainder <= '0;
                    end else if (r_rem[N-1:0] >= r_d) begin
                        // High half >= divisor: quotient would need more than N bits.
                        r_ovf       <= 1'b1;
                        r_quotient  <= '1;
                        r_remainder <= '0;
                    end else begin
                        r_cnt <= CW'(N - 1);
                    end
                end
                S_ITER: begin
                    r_rem <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    // Publish on the final step so results are valid during DONE.
                    if (r_cnt == '0) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
